// File: rtl/save_state_scheduler.sv
`default_nettype none
// ============================================================================
// save_state_scheduler: frame-aligned save/load arbiter for the save-state engine
// Revision: 1.0
// ============================================================================
module save_state_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int SLOT_BITS      = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 frame_boundary,
  input  logic                 btn_save,
  input  logic                 btn_load,
  input  logic [SLOT_BITS-1:0] btn_slot,
  input  logic                 host_req_valid,
  input  logic                 host_req_op,
  input  logic [SLOT_BITS-1:0] host_req_slot,
  output logic                 host_req_ready,
  input  logic                 engine_stall,
  output logic                 begin_save_state,
  output logic                 begin_load_state,
  output logic [SLOT_BITS-1:0] slot_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 resp_owner,
  output logic [NUM_SLOTS-1:0] slot_valid
);

  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ISSUE      = 2'd2,
    RUN        = 2'd3
  } state_t;

  state_t state, state_next;

  logic                 btn_save_q, btn_load_q;
  logic                 btn_pend, btn_op;
  logic [SLOT_BITS-1:0] btn_pslot;
  logic                 host_pend, host_op;
  logic [SLOT_BITS-1:0] host_pslot;
  logic                 last_grant;  // 1 = host was granted last
  logic                 cur_op;      // 0 = save, 1 = load
  logic [CNT_BITS-1:0]  run_cnt;

  logic                 save_rise, load_rise, btn_capture, host_accept;
  logic                 grant, grant_btn, grant_op, grant_bad;
  logic [SLOT_BITS-1:0] grant_slot;
  logic                 set_begin, set_done, set_error;

  assign save_rise      = btn_save & ~btn_save_q;
  assign load_rise      = btn_load & ~btn_load_q;
  assign btn_capture    = ~btn_pend & (save_rise | load_rise);
  assign host_req_ready = ~host_pend;
  assign host_accept    = host_req_valid & ~host_pend;
  assign busy           = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_btn  = 1'b0;
    grant_op   = 1'b0;
    grant_slot = '0;
    grant_bad  = 1'b0;
    set_begin  = 1'b0;
    set_done   = 1'b0;
    set_error  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_pend | host_pend) begin
          grant      = 1'b1;
          grant_btn  = btn_pend & (~host_pend | last_grant);
          grant_op   = grant_btn ? btn_op : host_op;
          grant_slot = grant_btn ? btn_pslot : host_pslot;
          // Loading an empty slot is rejected without touching the engine
          grant_bad  = grant_op & ~slot_valid[grant_slot];
          if (grant_bad) set_error  = 1'b1;
          else           state_next = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_boundary) begin
          set_begin  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = RUN;
      RUN: begin
        if (!engine_stall) begin
          set_done   = 1'b1;
          state_next = IDLE;
        end else if (run_cnt == CNT_LAST) begin
          set_error  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      btn_save_q       <= 1'b0;
      btn_load_q       <= 1'b0;
      btn_pend         <= 1'b0;
      btn_op           <= 1'b0;
      btn_pslot        <= '0;
      host_pend        <= 1'b0;
      host_op          <= 1'b0;
      host_pslot       <= '0;
      last_grant       <= 1'b1;
      cur_op           <= 1'b0;
      slot_sel         <= '0;
      resp_owner       <= 1'b0;
      run_cnt          <= '0;
      begin_save_state <= 1'b0;
      begin_load_state <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      slot_valid       <= '0;
    end else begin
      btn_save_q <= btn_save;
      btn_load_q <= btn_load;

      // Save takes precedence when both buttons rise together
      if (grant && grant_btn) begin
        btn_pend <= 1'b0;
      end else if (btn_capture) begin
        btn_pend  <= 1'b1;
        btn_op    <= ~save_rise;
        btn_pslot <= btn_slot;
      end

      if (grant && !grant_btn) begin
        host_pend <= 1'b0;
      end else if (host_accept) begin
        host_pend  <= 1'b1;
        host_op    <= host_req_op;
        host_pslot <= host_req_slot;
      end

      if (grant) begin
        last_grant <= ~grant_btn;
        cur_op     <= grant_op;
        slot_sel   <= grant_slot;
        resp_owner <= ~grant_btn;
      end

      if (state == ISSUE)    run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + 1'b1;

      begin_save_state <= set_begin & ~cur_op;
      begin_load_state <= set_begin & cur_op;
      done             <= set_done;
      error            <= set_error;

      if (set_done && !cur_op) slot_valid[slot_sel] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_save_state_scheduler.sv
`default_nettype none
// Directed bench for save_state_scheduler; a second instance uses a short timeout.
module tb_save_state_scheduler;

  localparam int NS = 4;
  localparam int SB = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_boundary = 1'b0;
  logic          btn_save = 1'b0, btn_load = 1'b0;
  logic [SB-1:0] btn_slot = '0;
  logic          host_req_valid = 1'b0, host_req_op = 1'b0;
  logic [SB-1:0] host_req_slot = '0;
  logic          engine_stall = 1'b0;

  logic          host_req_ready, begin_save_state, begin_load_state, busy, done, error, resp_owner;
  logic [SB-1:0] slot_sel;
  logic [NS-1:0] slot_valid;

  logic          host_req_ready_t, begin_save_t, begin_load_t, busy_t, done_t, error_t, resp_owner_t;
  logic [SB-1:0] slot_sel_t;
  logic [NS-1:0] slot_valid_t;

  int n_checks = 0;
  int n_pass   = 0;

  save_state_scheduler #(.NUM_SLOTS(NS), .SLOT_BITS(SB), .TIMEOUT_CYCLES(65535)) dut (
    .clock(clock), .reset_n(reset_n), .frame_boundary(frame_boundary),
    .btn_save(btn_save), .btn_load(btn_load), .btn_slot(btn_slot),
    .host_req_valid(host_req_valid), .host_req_op(host_req_op), .host_req_slot(host_req_slot),
    .host_req_ready(host_req_ready), .engine_stall(engine_stall),
    .begin_save_state(begin_save_state), .begin_load_state(begin_load_state),
    .slot_sel(slot_sel), .busy(busy), .done(done), .error(error),
    .resp_owner(resp_owner), .slot_valid(slot_valid)
  );

  save_state_scheduler #(.NUM_SLOTS(NS), .SLOT_BITS(SB), .TIMEOUT_CYCLES(100)) dut_t (
    .clock(clock), .reset_n(reset_n), .frame_boundary(frame_boundary),
    .btn_save(btn_save), .btn_load(btn_load), .btn_slot(btn_slot),
    .host_req_valid(host_req_valid), .host_req_op(host_req_op), .host_req_slot(host_req_slot),
    .host_req_ready(host_req_ready_t), .engine_stall(engine_stall),
    .begin_save_state(begin_save_t), .begin_load_state(begin_load_t),
    .slot_sel(slot_sel_t), .busy(busy_t), .done(done_t), .error(error_t),
    .resp_owner(resp_owner_t), .slot_valid(slot_valid_t)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Frame pulse, begin check, stall for stall_n extra RUN cycles, then done check
  task automatic run_engine(input string tag, input int stall_n, input logic exp_load,
                            input logic exp_owner);
    int stray;
    frame_boundary = 1'b1;
    tick();
    frame_boundary = 1'b0;
    check({tag, "_begin_save"}, 32'(begin_save_state), 32'(!exp_load));
    check({tag, "_begin_load"}, 32'(begin_load_state), 32'(exp_load));
    engine_stall = 1'b1;
    stray = 0;
    tick();
    if (done | error | begin_save_state | begin_load_state) stray++;
    for (int i = 0; i < stall_n; i++) begin
      tick();
      if (done | error | begin_save_state | begin_load_state) stray++;
    end
    check({tag, "_no_stray_pulse"}, 32'(stray), 32'd0);
    engine_stall = 1'b0;
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_owner"}, 32'(resp_owner), 32'(exp_owner));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;

    // Reset state
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_slot_valid", 32'(slot_valid), 32'd0);
    check("rst_slot_sel", 32'(slot_sel), 32'd0);
    check("rst_pulses", 32'({done, error, begin_save_state, begin_load_state}), 32'd0);
    reset_n = 1'b1;
    check("rst_ready", 32'(host_req_ready), 32'd1);

    // Host save slot 2, frame 10 cycles after grant, 300 stall cycles
    host_req_valid = 1'b1; host_req_op = 1'b0; host_req_slot = 2'd2;
    tick();
    host_req_valid = 1'b0;
    check("t2_ready_low", 32'(host_req_ready), 32'd0);
    check("t2_not_busy_yet", 32'(busy), 32'd0);
    tick();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_slot_sel", 32'(slot_sel), 32'd2);
    repeat (9) tick();
    check("t2_still_waiting", 32'(begin_save_state), 32'd0);
    run_engine("t2", 300, 1'b0, 1'b1);
    check("t2_slot_valid", 32'(slot_valid), 32'b0100);
    tick();
    check("t2_done_one_cycle", 32'(done), 32'd0);

    // Host load of empty slot 1
    host_req_valid = 1'b1; host_req_op = 1'b1; host_req_slot = 2'd1;
    tick();
    host_req_valid = 1'b0;
    tick();
    check("t3_error", 32'(error), 32'd1);
    check("t3_owner", 32'(resp_owner), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy | begin_save_state | begin_load_state | error | done) cnt++;
    end
    check("t3_no_activity", 32'(cnt), 32'd0);

    // Button and host pending together: button first
    btn_save = 1'b1; btn_slot = 2'd0;
    host_req_valid = 1'b1; host_req_op = 1'b0; host_req_slot = 2'd3;
    tick();
    btn_save = 1'b0; host_req_valid = 1'b0;
    tick();
    check("t4_btn_busy", 32'(busy), 32'd1);
    check("t4_btn_slot", 32'(slot_sel), 32'd0);
    run_engine("t4a", 5, 1'b0, 1'b0);
    check("t4a_slot_valid", 32'(slot_valid), 32'b0101);
    tick();
    check("t4_host_busy", 32'(busy), 32'd1);
    check("t4_host_slot", 32'(slot_sel), 32'd3);
    run_engine("t4b", 5, 1'b0, 1'b1);
    check("t4b_slot_valid", 32'(slot_valid), 32'b1101);

    // Two button presses while busy: only the first is kept
    btn_save = 1'b1; btn_slot = 2'd1;
    tick();
    btn_save = 1'b0;
    tick();
    check("t5_first_slot", 32'(slot_sel), 32'd1);
    btn_save = 1'b1; btn_slot = 2'd2;
    tick();
    btn_save = 1'b0;
    tick();
    btn_save = 1'b1; btn_slot = 2'd3;
    tick();
    btn_save = 1'b0;
    tick();
    run_engine("t5a", 3, 1'b0, 1'b0);
    tick();
    check("t5_second_busy", 32'(busy), 32'd1);
    check("t5_second_slot", 32'(slot_sel), 32'd2);
    run_engine("t5b", 3, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) cnt++;
    end
    check("t5_no_third_op", 32'(cnt), 32'd0);
    check("t5_slot_valid", 32'(slot_valid), 32'b1111);

    // Reset during RUN, host request held high through reset
    host_req_valid = 1'b1; host_req_op = 1'b0; host_req_slot = 2'd0;
    tick();
    host_req_valid = 1'b0;
    tick();
    frame_boundary = 1'b1;
    tick();
    frame_boundary = 1'b0;
    engine_stall = 1'b1;
    repeat (20) tick();
    check("t7_in_run", 32'(busy), 32'd1);
    reset_n = 1'b0;
    host_req_valid = 1'b1; host_req_op = 1'b0; host_req_slot = 2'd1;
    tick();
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_slot_valid", 32'(slot_valid), 32'd0);
    check("t7_no_done", 32'(done | error), 32'd0);
    reset_n = 1'b1;
    check("t7_ready", 32'(host_req_ready), 32'd1);
    tick();
    host_req_valid = 1'b0;
    check("t7_accepted", 32'(host_req_ready), 32'd0);
    tick();
    check("t7_granted", 32'(busy), 32'd1);
    check("t7_slot_sel", 32'(slot_sel), 32'd1);

    // Timeout on the short-timeout instance
    reset_n = 1'b0;
    engine_stall = 1'b0;
    tick();
    reset_n = 1'b1;
    host_req_valid = 1'b1; host_req_op = 1'b0; host_req_slot = 2'd0;
    tick();
    host_req_valid = 1'b0;
    tick();
    frame_boundary = 1'b1;
    tick();
    frame_boundary = 1'b0;
    check("t6_begin", 32'(begin_save_t), 32'd1);
    engine_stall = 1'b1;
    cnt = 0;
    while (cnt < 300 && !error_t) begin
      tick();
      cnt++;
    end
    check("t6_error_latency", 32'(cnt), 32'd101);
    check("t6_no_done", 32'(done_t), 32'd0);
    check("t6_slot_valid", 32'(slot_valid_t), 32'd0);
    check("t6_idle", 32'(busy_t), 32'd0);
    tick();
    check("t6_error_one_cycle", 32'(error_t), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
